sdram_port_arb: RTL

Upstream front end for the 8-clock-slot SDRAM controller. Generates the controller's slot sync and time-multiplexes two requesters onto its single async-DRAM-style port: a CPU port (read/write) and a video fetch port (read-only). Each slot carries one access or, when idle, lets the controller auto-refresh. Returns read data and a one-cycle ack to the granted port.

---
 rtl/sdram_arb_pkg.sv | 13 +
 rtl/sdram_slot_timer.sv | 36 +++
 rtl/sdram_port_arb.sv | 125 ++++++++++++
 3 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared constants for the SDRAM port arbiter: slot timing and grant encoding.
package sdram_arb_pkg;

  localparam int SLOT_LEN     = 8;
  localparam int RD_CAPTURE   = 7;
  localparam int SYNC_HI_LAST = 3;
  localparam int CNT_W        = $clog2(SLOT_LEN);

  localparam logic [1:0] PORT_NONE = 2'd0;
  localparam logic [1:0] PORT_CPU  = 2'd1;
  localparam logic [1:0] PORT_VID  = 2'd2;

endpackage

// File: rtl/sdram_slot_timer.sv
// Free-running slot counter producing the controller's registered slot sync
// plus the decision (cnt 0) and read-capture strobes for the arbiter.
module sdram_slot_timer
  import sdram_arb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  output logic o_sync,
  output logic o_decide,
  output logic o_capture
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_sync;

  always_comb begin
    w_cnt_nxt = (r_cnt == CNT_W'(SLOT_LEN - 1)) ? '0 : r_cnt + 1'b1;
  end

  // Sync is registered from the next count so it is high exactly while cnt is 0..3.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_sync <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_sync <= (w_cnt_nxt <= CNT_W'(SYNC_HI_LAST));
    end
  end

  assign o_sync    = r_sync;
  assign o_decide  = (r_cnt == '0);
  assign o_capture = (r_cnt == CNT_W'(RD_CAPTURE));

endmodule

// File: rtl/sdram_port_arb.sv
// Time-multiplexes a CPU read/write port and a video read port onto the
// slotted SDRAM controller, one access per slot with alternating tie-break.
module sdram_port_arb
  import sdram_arb_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [19:0] cpu_addr,
  input  logic [1:0]  cpu_ds,
  input  logic [15:0] cpu_din,
  output logic [15:0] cpu_dout,
  output logic        cpu_ack,
  input  logic        vid_req,
  input  logic [19:0] vid_addr,
  output logic [15:0] vid_dout,
  output logic        vid_ack,
  output logic        sd_sync,
  output logic [19:0] sd_addr,
  output logic [15:0] sd_din,
  output logic [1:0]  sd_ds,
  output logic        sd_oe,
  output logic        sd_we,
  input  logic [15:0] sd_dout
);

  logic        w_decide;
  logic        w_capture;
  logic        w_cpu_e;
  logic        w_vid_e;
  logic [1:0]  w_pick;
  logic [1:0]  r_grant;
  logic        r_last_cpu;
  logic [19:0] r_sd_addr;
  logic [15:0] r_sd_din;
  logic [1:0]  r_sd_ds;
  logic        r_sd_oe;
  logic        r_sd_we;
  logic        r_cpu_ack;
  logic        r_vid_ack;
  logic [15:0] r_cpu_dout;
  logic [15:0] r_vid_dout;

  sdram_slot_timer u_timer (
    .clk       (clk),
    .reset     (reset),
    .o_sync    (sd_sync),
    .o_decide  (w_decide),
    .o_capture (w_capture)
  );

  // A requester still holding req during its ack cycle is not yet a new request.
  always_comb begin
    w_cpu_e = cpu_req & ~r_cpu_ack;
    w_vid_e = vid_req & ~r_vid_ack;
    w_pick  = PORT_NONE;
    if (w_cpu_e && w_vid_e) w_pick = r_last_cpu ? PORT_VID : PORT_CPU;
    else if (w_cpu_e)       w_pick = PORT_CPU;
    else if (w_vid_e)       w_pick = PORT_VID;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_grant    <= PORT_NONE;
      r_last_cpu <= 1'b1;
      r_sd_addr  <= '0;
      r_sd_din   <= '0;
      r_sd_ds    <= '0;
      r_sd_oe    <= 1'b0;
      r_sd_we    <= 1'b0;
      r_cpu_ack  <= 1'b0;
      r_vid_ack  <= 1'b0;
      r_cpu_dout <= '0;
      r_vid_dout <= '0;
    end else begin
      r_cpu_ack <= 1'b0;
      r_vid_ack <= 1'b0;
      if (w_decide) begin
        r_grant <= w_pick;
        case (w_pick)
          PORT_CPU: begin
            r_sd_addr  <= cpu_addr;
            r_sd_din   <= cpu_din;
            r_sd_ds    <= cpu_ds;
            r_sd_oe    <= ~cpu_we;
            r_sd_we    <= cpu_we;
            r_last_cpu <= 1'b1;
          end
          PORT_VID: begin
            r_sd_addr  <= vid_addr;
            r_sd_ds    <= 2'b11;
            r_sd_oe    <= 1'b1;
            r_sd_we    <= 1'b0;
            r_last_cpu <= 1'b0;
          end
          default: begin
            r_sd_oe <= 1'b0;
            r_sd_we <= 1'b0;
          end
        endcase
      end
      if (w_capture) begin
        if (r_grant == PORT_CPU) begin
          r_cpu_ack <= 1'b1;
          if (!r_sd_we) r_cpu_dout <= sd_dout;
        end else if (r_grant == PORT_VID) begin
          r_vid_ack  <= 1'b1;
          r_vid_dout <= sd_dout;
        end
      end
    end
  end

  assign sd_addr  = r_sd_addr;
  assign sd_din   = r_sd_din;
  assign sd_ds    = r_sd_ds;
  assign sd_oe    = r_sd_oe;
  assign sd_we    = r_sd_we;
  assign cpu_ack  = r_cpu_ack;
  assign vid_ack  = r_vid_ack;
  assign cpu_dout = r_cpu_dout;
  assign vid_dout = r_vid_dout;

endmodule
